// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR fault monitor.
//   tmr_evt_kind_e : event kind reported to the reader (single / uncorrectable / permanent)
//   tmr_evt_t      : one queued event {kind, replica}
//   tmr_class_e    : classification of one sampled cycle
//   tmr_classify   : maps the three pairwise-equality results to a class
//   tmr_odd_replica: index (1..3) of the disagreeing replica, 0 when none is singled out
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    TMR_EVT_SINGLE = 2'b00,
    TMR_EVT_UNCORR = 2'b01,
    TMR_EVT_PERM   = 2'b10
  } tmr_evt_kind_e;

  typedef struct packed {
    tmr_evt_kind_e kind;
    logic [1:0]    replica;
  } tmr_evt_t;

  typedef enum logic [1:0] {
    TMR_CLEAN  = 2'd0,
    TMR_SINGLE = 2'd1,
    TMR_UNCORR = 2'd2
  } tmr_class_e;

  // Equality is transitive, so two equal pairs imply all three equal and
  // exactly one equal pair means exactly one replica is the odd one out.
  function automatic tmr_class_e tmr_classify(input logic eq12, input logic eq13,
                                               input logic eq23);
    if (eq12 && eq13)                  return TMR_CLEAN;
    else if (!eq12 && !eq13 && !eq23)  return TMR_UNCORR;
    else                               return TMR_SINGLE;
  endfunction

  function automatic logic [1:0] tmr_odd_replica(input logic eq12, input logic eq13,
                                                 input logic eq23);
    if (eq23 && !eq12)       return 2'd1;
    else if (eq13 && !eq12)  return 2'd2;
    else if (eq12 && !eq13)  return 2'd3;
    else                     return 2'd0;
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_fault_monitor_if.sv
// Event channel from the fault monitor to a debug/CSR reader.
//   valid   : an event is presented
//   ready   : reader accepts the presented event
//   kind    : event kind (single / uncorrectable / permanent)
//   replica : replica index 1..3, 0 for uncorrectable
// master = monitor side, slave = reader side.
interface cv32e40p_tmr_fault_monitor_if;
  import cv32e40p_pkg::*;

  logic          valid;
  logic          ready;
  tmr_evt_kind_e kind;
  logic [1:0]    replica;

  modport master (output valid, kind, replica, input ready);
  modport slave  (input valid, kind, replica, output ready);

endinterface

// File: rtl/cv32e40p_tmr_evt_fifo.sv
// Two-entry event FIFO with synchronous flush.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous discard of all entries
//   push_valid : write push_data (accepted when not full, or full with a pop this cycle)
//   push_data  : event to enqueue
//   full/empty : occupancy status
//   pop_ready  : consumer takes the head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
module cv32e40p_tmr_evt_fifo
  import cv32e40p_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push_valid,
  input  tmr_evt_t push_data,
  output logic     full,
  output logic     empty,
  input  logic     pop_ready,
  output tmr_evt_t pop_data
);

  tmr_evt_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       pop_fire;
  logic       push_ok;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign pop_fire = pop_ready && !empty;
  // When full, the slot being popped this cycle is the one wr_ptr points at,
  // so a simultaneous push can reuse it without disturbing order.
  assign push_ok  = push_valid && (!full || pop_fire);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok)  wr_ptr <= ~wr_ptr;
      if (pop_fire) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_fire};
    end
  end

  // NOTE: storage is not reset; pointers/count define validity and the
  // output is masked while empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? tmr_evt_t'('0) : mem[rd_ptr];

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Diagnostic monitor for a triplicated unit. Classifies each sampled cycle of
// the three replica outputs (clean / single-replica fault / uncorrectable),
// keeps saturating per-replica error counts and queues fault events.
// Optional feature macro: CV32E40P_TMR_PERSIST_EN enables persistent-failure
// detection (persist counters, sticky faulty_o, kind-10 events). When undefined
// faulty_o is tied to 0 and every single mismatch reports kind 00.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sample_i            : replica outputs valid and compared this cycle
//   data1_i..data3_i    : replica outputs
//   clear_i             : clears counters, sticky flags and event queue (wins over sample_i)
//   err_cnt1_o..3_o     : saturating mismatch count per replica
//   uncorr_cnt_o        : saturating count of all-differ cycles
//   faulty_o            : sticky permanent-fault flag per replica (bit0 = replica 1)
//   evt                 : event channel (valid/ready, kind, replica)
//   evt_overflow_o      : sticky, an event was dropped because the queue was full
module cv32e40p_tmr_fault_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NBIT       = 32,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PERSIST_TH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_i,
  input  logic [NBIT-1:0]       data1_i,
  input  logic [NBIT-1:0]       data2_i,
  input  logic [NBIT-1:0]       data3_i,
  input  logic                  clear_i,
  output logic [CNT_W-1:0]      err_cnt1_o,
  output logic [CNT_W-1:0]      err_cnt2_o,
  output logic [CNT_W-1:0]      err_cnt3_o,
  output logic [CNT_W-1:0]      uncorr_cnt_o,
  output logic [2:0]            faulty_o,
  cv32e40p_tmr_fault_monitor_if.master evt,
  output logic                  evt_overflow_o
);

  logic             eq12, eq13, eq23;
  tmr_class_e       cls;
  logic [1:0]       odd;
  logic             active;
  logic             is_clean, is_single, is_uncorr;
  logic [CNT_W-1:0] err_cnt [3];
  logic [CNT_W-1:0] uncorr_cnt;
  logic             evt_push;
  tmr_evt_t         evt_data;
  tmr_evt_t         head;
  logic             fifo_full, fifo_empty, pop_fire;
  logic             overflow;

  assign eq12 = (data1_i == data2_i);
  assign eq13 = (data1_i == data3_i);
  assign eq23 = (data2_i == data3_i);
  assign cls  = tmr_classify(eq12, eq13, eq23);
  assign odd  = tmr_odd_replica(eq12, eq13, eq23);

  // A clear in the same cycle discards the sample entirely.
  assign active    = sample_i && !clear_i;
  assign is_clean  = active && (cls == TMR_CLEAN);
  assign is_single = active && (cls == TMR_SINGLE);
  assign is_uncorr = active && (cls == TMR_UNCORR);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int k = 0; k < 3; k++) err_cnt[k] <= '0;
      uncorr_cnt <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (is_single && odd == 2'(k + 1) && err_cnt[k] != '1)
          err_cnt[k] <= err_cnt[k] + 1'b1;
      end
      if (is_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

  assign err_cnt1_o   = err_cnt[0];
  assign err_cnt2_o   = err_cnt[1];
  assign err_cnt3_o   = err_cnt[2];
  assign uncorr_cnt_o = uncorr_cnt;

`ifdef CV32E40P_TMR_PERSIST_EN
  logic [3:0] persist_cnt [3];
  logic [3:0] persist_nxt [3];
  logic [2:0] perm_hit;
  logic [2:0] faulty;
  logic [2:0] odd_oh;

  assign odd_oh = {odd == 2'd3, odd == 2'd2, odd == 2'd1};

  // Uncorrectable and unsampled cycles leave the persist counters alone;
  // counters saturate at 15 so a long-failed replica cannot wrap back to
  // the threshold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    for (int k = 0; k < 3; k++) begin
      persist_nxt[k] = persist_cnt[k];
      perm_hit[k]    = 1'b0;
      if (is_clean) begin
        persist_nxt[k] = 4'd0;
      end else if (is_single) begin
        if (odd_oh[k]) begin
          persist_nxt[k] = (persist_cnt[k] == 4'hF) ? 4'hF : persist_cnt[k] + 4'd1;
          perm_hit[k]    = (persist_nxt[k] == 4'(PERSIST_TH));
        end else begin
          persist_nxt[k] = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int k = 0; k < 3; k++) persist_cnt[k] <= 4'd0;
      faulty <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) persist_cnt[k] <= persist_nxt[k];
      faulty <= faulty | perm_hit;
    end
  end

  assign faulty_o = faulty;
`else
  assign faulty_o = 3'b000;
`endif

  always_comb begin
    evt_push = 1'b0;
    evt_data = '{kind: TMR_EVT_SINGLE, replica: 2'd0};
    if (is_single) begin
`ifdef CV32E40P_TMR_PERSIST_EN
      // A replica already declared faulty keeps counting but stays silent.
      evt_push      = ~|(faulty & odd_oh);
      evt_data.kind = (|perm_hit) ? TMR_EVT_PERM : TMR_EVT_SINGLE;
`else
      evt_push      = 1'b1;
`endif
      evt_data.replica = odd;
    end else if (is_uncorr) begin
      evt_push      = 1'b1;
      evt_data.kind = TMR_EVT_UNCORR;
    end
  end

  cv32e40p_tmr_evt_fifo u_evt_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (clear_i),
    .push_valid (evt_push),
    .push_data  (evt_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .pop_ready  (evt.ready),
    .pop_data   (head)
  );

  assign pop_fire    = evt.ready && !fifo_empty;
  assign evt.valid   = !fifo_empty;
  assign evt.kind    = head.kind;
  assign evt.replica = head.replica;

  always_ff @(posedge clk) begin
    if (rst || clear_i)                            overflow <= 1'b0;
    else if (evt_push && fifo_full && !pop_fire)   overflow <= 1'b1;
  end

  assign evt_overflow_o = overflow;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Directed self-checking bench for cv32e40p_tmr_fault_monitor (PERSIST_TH=4).
// Expectations follow the CV32E40P_TMR_PERSIST_EN build setting.
module tb_cv32e40p_tmr_fault_monitor;
  import cv32e40p_pkg::*;

`ifdef CV32E40P_TMR_PERSIST_EN
  localparam bit PERSIST = 1'b1;
`else
  localparam bit PERSIST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample;
  logic [31:0] d1, d2, d3;
  logic        clear;
  logic [7:0]  err_cnt1, err_cnt2, err_cnt3, uncorr_cnt;
  logic [2:0]  faulty;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  cv32e40p_tmr_fault_monitor_if evt_if ();

  cv32e40p_tmr_fault_monitor #(.NBIT(32), .CNT_W(8), .PERSIST_TH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample),
    .data1_i        (d1),
    .data2_i        (d2),
    .data3_i        (d3),
    .clear_i        (clear),
    .err_cnt1_o     (err_cnt1),
    .err_cnt2_o     (err_cnt2),
    .err_cnt3_o     (err_cnt3),
    .uncorr_cnt_o   (uncorr_cnt),
    .faulty_o       (faulty),
    .evt            (evt_if),
    .evt_overflow_o (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_once(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    d1 = a; d2 = b; d3 = c;
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  // Check the head event, then pop it.
  task automatic expect_evt(input string tag, input tmr_evt_kind_e kind, input logic [1:0] rep);
    check({tag, "_valid"}, 32'(evt_if.valid), 32'd1);
    check({tag, "_kind"}, 32'(evt_if.kind), 32'(kind));
    check({tag, "_replica"}, 32'(evt_if.replica), 32'(rep));
    evt_if.ready = 1'b1;
    step();
    evt_if.ready = 1'b0;
  endtask

  initial begin
    tmr_evt_kind_e exp_kind;
    rst = 1'b1; sample = 1'b0; clear = 1'b0;
    d1 = '0; d2 = '0; d3 = '0;
    evt_if.ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_err1", 32'(err_cnt1), 32'd0);
    check("rst_err2", 32'(err_cnt2), 32'd0);
    check("rst_err3", 32'(err_cnt3), 32'd0);
    check("rst_uncorr", 32'(uncorr_cnt), 32'd0);
    check("rst_faulty", 32'(faulty), 32'd0);
    check("rst_valid", 32'(evt_if.valid), 32'd0);
    check("rst_kind", 32'(evt_if.kind), 32'd0);
    check("rst_replica", 32'(evt_if.replica), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Ten clean samples
    d1 = 32'hA5A5A5A5; d2 = 32'hA5A5A5A5; d3 = 32'hA5A5A5A5;
    sample = 1'b1;
    for (int i = 0; i < 10; i++) step();
    sample = 1'b0;
    check("clean_err1", 32'(err_cnt1), 32'd0);
    check("clean_err2", 32'(err_cnt2), 32'd0);
    check("clean_err3", 32'(err_cnt3), 32'd0);
    check("clean_uncorr", 32'(uncorr_cnt), 32'd0);
    check("clean_valid", 32'(evt_if.valid), 32'd0);

    // Single mismatch on replica 2 with reader ready
    evt_if.ready = 1'b1;
    sample_once(32'h0, 32'h1, 32'h0);
    check("r2_valid", 32'(evt_if.valid), 32'd1);
    check("r2_kind", 32'(evt_if.kind), 32'(TMR_EVT_SINGLE));
    check("r2_replica", 32'(evt_if.replica), 32'd2);
    check("r2_err2", 32'(err_cnt2), 32'd1);
    check("r2_err1", 32'(err_cnt1), 32'd0);
    step();
    evt_if.ready = 1'b0;
    check("r2_drained", 32'(evt_if.valid), 32'd0);

    // Four consecutive mismatches on replica 3
    for (int i = 0; i < 4; i++) begin
      sample_once(32'h0, 32'h0, 32'h5);
      check("r3_err3", 32'(err_cnt3), 32'(i + 1));
      exp_kind = (i == 3 && PERSIST) ? TMR_EVT_PERM : TMR_EVT_SINGLE;
      expect_evt("r3_evt", exp_kind, 2'd3);
    end
    check("r3_faulty", 32'(faulty), PERSIST ? 32'b100 : 32'b000);
    sample_once(32'h0, 32'h0, 32'h5);
    check("r3_5th_err3", 32'(err_cnt3), 32'd5);
    check("r3_5th_valid", 32'(evt_if.valid), PERSIST ? 32'd0 : 32'd1);
    if (evt_if.valid) begin
      evt_if.ready = 1'b1; step(); evt_if.ready = 1'b0;
    end

    // Uncorrectable between replica-1 singles leaves persist counting intact
    sample_once(32'h0, 32'h0, 32'h0);
    sample_once(32'h7, 32'h0, 32'h0);
    expect_evt("r1a", TMR_EVT_SINGLE, 2'd1);
    sample_once(32'h1, 32'h2, 32'h3);
    check("unc_cnt", 32'(uncorr_cnt), 32'd1);
    expect_evt("unc", TMR_EVT_UNCORR, 2'd0);
    for (int i = 0; i < 3; i++) begin
      sample_once(32'h7, 32'h0, 32'h0);
      exp_kind = (i == 2 && PERSIST) ? TMR_EVT_PERM : TMR_EVT_SINGLE;
      expect_evt("r1b", exp_kind, 2'd1);
    end
    check("r1_err1", 32'(err_cnt1), 32'd4);
    sample_once(32'h9, 32'h9, 32'h9);
    check("sticky_faulty", 32'(faulty), PERSIST ? 32'b101 : 32'b000);

    // Overflow with a stalled reader: third event dropped, order kept
    sample_once(32'h0, 32'h4, 32'h0);
    sample_once(32'h1, 32'h2, 32'h3);
    check("ovf_before", 32'(overflow), 32'd0);
    sample_once(32'h0, 32'h4, 32'h0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_err2", 32'(err_cnt2), 32'd3);
    step();
    check("ovf_hold_kind", 32'(evt_if.kind), 32'(TMR_EVT_SINGLE));
    check("ovf_hold_replica", 32'(evt_if.replica), 32'd2);
    expect_evt("ovf_first", TMR_EVT_SINGLE, 2'd2);
    expect_evt("ovf_second", TMR_EVT_UNCORR, 2'd0);
    check("ovf_empty", 32'(evt_if.valid), 32'd0);

    // Push while full with simultaneous pop is accepted
    sample_once(32'h0, 32'h4, 32'h0);
    sample_once(32'h1, 32'h2, 32'h3);
    evt_if.ready = 1'b1;
    sample_once(32'h1, 32'h2, 32'h3);
    evt_if.ready = 1'b0;
    check("fullpop_uncorr", 32'(uncorr_cnt), 32'd4);
    check("fullpop_err2", 32'(err_cnt2), 32'd4);
    expect_evt("fullpop_a", TMR_EVT_UNCORR, 2'd0);
    expect_evt("fullpop_b", TMR_EVT_UNCORR, 2'd0);
    check("fullpop_empty", 32'(evt_if.valid), 32'd0);

    // Clear coincident with a mismatching sample
    sample_once(32'h1, 32'h2, 32'h3);
    clear = 1'b1;
    sample_once(32'h0, 32'h8, 32'h0);
    clear = 1'b0;
    check("clr_err1", 32'(err_cnt1), 32'd0);
    check("clr_err2", 32'(err_cnt2), 32'd0);
    check("clr_err3", 32'(err_cnt3), 32'd0);
    check("clr_uncorr", 32'(uncorr_cnt), 32'd0);
    check("clr_faulty", 32'(faulty), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_valid", 32'(evt_if.valid), 32'd0);
    step();
    check("clr_no_evt", 32'(evt_if.valid), 32'd0);

    // Reset mid-queue
    sample_once(32'h1, 32'h2, 32'h3);
    sample_once(32'h1, 32'h2, 32'h3);
    sample_once(32'h1, 32'h2, 32'h3);
    check("pre_rst_valid", 32'(evt_if.valid), 32'd1);
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 32'(evt_if.valid), 32'd0);
    check("mrst_uncorr", 32'(uncorr_cnt), 32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_kind", 32'(evt_if.kind), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
